merkle_leaf_collector: RTL and testbench

- Upstream feeder of the Merkle commitment-root stage.
- Accepts per-round 256-bit leaf commitments one at a time on a valid/ready stream and packs NUM_LEAVES of them into the flat leaf bus. Latches the salt with the first leaf.
- Runs the tree_start / tree_set_end handshake with the tree stage, then captures the root and offers it downstream on a valid/ready output.

---
 rtl/merkle_pkg.sv | 19 +
 rtl/merkle_leaf_pack.sv | 72 +++++++
 rtl/merkle_leaf_collector.sv | 162 ++++++++++++++++
 tb/tb_merkle_leaf_collector.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/merkle_pkg.sv
// Shared constants, state encoding and leaf-slice helper for the Merkle leaf collector.
package merkle_pkg;

    localparam int HASH_W     = 256;
    localparam int NUM_LEAVES = 8;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    // Leaf 0 sits in the most-significant slice of the flat leaf bus.
    function automatic int leaf_slice_msb(input int k, input int n, input int w);
        return (n - k) * w - 1;
    endfunction

endpackage

// File: rtl/merkle_leaf_pack.sv
// Leaf register file: packs accepted commitments into the flat bus, latches the salt with leaf 0.
module merkle_leaf_pack
    import merkle_pkg::*;
#(
    parameter int N_LEAVES = merkle_pkg::NUM_LEAVES,
    parameter int W        = merkle_pkg::HASH_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  clear,
    input  logic [W-1:0]          cm_in,
    input  logic [W-1:0]          salt_in,
    output logic [N_LEAVES*W-1:0] ch,
    output logic [W-1:0]          salt,
    output logic                  last
);

    localparam int IDX_W = (N_LEAVES > 1) ? $clog2(N_LEAVES) : 1;

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [N_LEAVES*W-1:0] ch_q, ch_d;
    logic [W-1:0]          salt_q, salt_d;

    assign last = (idx_q == IDX_W'(N_LEAVES - 1));
    assign ch   = ch_q;
    assign salt = salt_q;

    // Next-state for the leaf slots, salt and write index.
    always_comb begin
        idx_d  = idx_q;
        ch_d   = ch_q;
        salt_d = salt_q;
        if (clear) begin
            ch_d = '0;
        end else if (wr_en) begin
            for (int k = 0; k < N_LEAVES; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    ch_d[leaf_slice_msb(k, N_LEAVES, W) -: W] = cm_in;
                end else begin
                    ch_d[leaf_slice_msb(k, N_LEAVES, W) -: W] = ch_q[leaf_slice_msb(k, N_LEAVES, W) -: W];
                end
            end
            if (idx_q == IDX_W'(0)) begin
                salt_d = salt_in;
            end else begin
                salt_d = salt_q;
            end
            if (last) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Leaf storage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q  <= '0;
            ch_q   <= '0;
            salt_q <= '0;
        end else begin
            idx_q  <= idx_d;
            ch_q   <= ch_d;
            salt_q <= salt_d;
        end
    end

endmodule

// File: rtl/merkle_leaf_collector.sv
// Collects NUM_LEAVES commitments, drives the tree_start/tree_set_end handshake and offers the root.
// Optional busy-cycle counter output tree_cycles is enabled by defining MERKLE_COLLECTOR_PERF_EN.
module merkle_leaf_collector
    import merkle_pkg::*;
#(
    parameter int N_LEAVES = merkle_pkg::NUM_LEAVES,
    parameter int W        = merkle_pkg::HASH_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [W-1:0]          cm_in,
    input  logic                  cm_valid,
    output logic                  cm_ready,
    input  logic [W-1:0]          salt_in,
    output logic [N_LEAVES*W-1:0] ch,
    output logic [W-1:0]          salt,
    output logic                  tree_start,
    input  logic                  tree_set_end,
    input  logic [W-1:0]          chroot,
    output logic [W-1:0]          root_out,
    output logic                  root_valid,
`ifdef MERKLE_COLLECTOR_PERF_EN
    output logic [15:0]           tree_cycles,
`endif
    input  logic                  root_ready
);

    state_e       state_q, state_d;
    logic         tree_start_q, tree_start_d;
    logic [W-1:0] root_out_q, root_out_d;
    logic         root_valid_q, root_valid_d;
    logic         accept;
    logic         clear;
    logic         last_leaf;

    assign cm_ready   = (state_q == ST_FILL);
    assign accept     = cm_valid && cm_ready;
    assign clear      = (state_q == ST_RESULT) && root_valid_q && root_ready;
    assign tree_start = tree_start_q;
    assign root_out   = root_out_q;
    assign root_valid = root_valid_q;

    merkle_leaf_pack #(
        .N_LEAVES (N_LEAVES),
        .W        (W)
    ) u_pack (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .clear   (clear),
        .cm_in   (cm_in),
        .salt_in (salt_in),
        .ch      (ch),
        .salt    (salt),
        .last    (last_leaf)
    );

    // FSM next-state and handshake outputs.
    always_comb begin
        state_d      = state_q;
        tree_start_d = tree_start_q;
        root_out_d   = root_out_q;
        root_valid_d = root_valid_q;
        case (state_q)
            ST_FILL: begin
                if (accept && last_leaf) begin
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_LAUNCH: begin
                // A done flag left over from the previous tree must drop before starting.
                if (!tree_set_end) begin
                    tree_start_d = 1'b1;
                    state_d      = ST_BUSY;
                end else begin
                    tree_start_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (tree_set_end) begin
                    root_out_d   = chroot;
                    root_valid_d = 1'b1;
                    tree_start_d = 1'b0;
                    state_d      = ST_RESULT;
                end else begin
                    tree_start_d = 1'b1;
                end
            end
            ST_RESULT: begin
                if (root_valid_q && root_ready) begin
                    root_valid_d = 1'b0;
                    state_d      = ST_FILL;
                end else begin
                    state_d = ST_RESULT;
                end
            end
            default: begin
                state_d      = ST_FILL;
                tree_start_d = 1'b0;
                root_valid_d = 1'b0;
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_FILL;
            tree_start_q <= 1'b0;
            root_out_q   <= '0;
            root_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tree_start_q <= tree_start_d;
            root_out_q   <= root_out_d;
            root_valid_q <= root_valid_d;
        end
    end

`ifdef MERKLE_COLLECTOR_PERF_EN
    logic [15:0] busy_cnt_q, busy_cnt_d;
    logic [15:0] tree_cycles_q, tree_cycles_d;

    assign tree_cycles = tree_cycles_q;

    // Busy-cycle counter; snapshot taken as the root is captured.
    always_comb begin
        busy_cnt_d    = busy_cnt_q;
        tree_cycles_d = tree_cycles_q;
        if ((state_q == ST_LAUNCH) && !tree_set_end) begin
            busy_cnt_d = 16'h0000;
        end else if (state_q == ST_BUSY) begin
            if (busy_cnt_q != 16'hFFFF) begin
                busy_cnt_d = busy_cnt_q + 16'h0001;
            end else begin
                busy_cnt_d = busy_cnt_q;
            end
            if (tree_set_end) begin
                tree_cycles_d = busy_cnt_q;
            end else begin
                tree_cycles_d = tree_cycles_q;
            end
        end else begin
            busy_cnt_d = busy_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_cnt_q    <= 16'h0000;
            tree_cycles_q <= 16'h0000;
        end else begin
            busy_cnt_q    <= busy_cnt_d;
            tree_cycles_q <= tree_cycles_d;
        end
    end
`endif

endmodule

// File: tb/tb_merkle_leaf_collector.sv
// Directed, table-driven bench for merkle_leaf_collector.
module tb_merkle_leaf_collector;

    localparam int NL = 8;
    localparam int HW = 256;

    logic               clk = 1'b0;
    logic               reset;
    logic [HW-1:0]      cm_in;
    logic               cm_valid;
    logic               cm_ready;
    logic [HW-1:0]      salt_in;
    logic [NL*HW-1:0]   ch;
    logic [HW-1:0]      salt;
    logic               tree_start;
    logic               tree_set_end;
    logic [HW-1:0]      chroot;
    logic [HW-1:0]      root_out;
    logic               root_valid;
    logic               root_ready;
`ifdef MERKLE_COLLECTOR_PERF_EN
    logic [15:0]        tree_cycles;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [HW-1:0] cm;
        logic [HW-1:0] salt;
        logic [7:0]    tag;
    } leaf_vec_t;

    leaf_vec_t vec[3][NL];
    logic [HW-1:0] batch_salt[3];

    merkle_leaf_collector dut (
        .clk          (clk),
        .reset        (reset),
        .cm_in        (cm_in),
        .cm_valid     (cm_valid),
        .cm_ready     (cm_ready),
        .salt_in      (salt_in),
        .ch           (ch),
        .salt         (salt),
        .tree_start   (tree_start),
        .tree_set_end (tree_set_end),
        .chroot       (chroot),
        .root_out     (root_out),
        .root_valid   (root_valid),
`ifdef MERKLE_COLLECTOR_PERF_EN
        .tree_cycles  (tree_cycles),
`endif
        .root_ready   (root_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic feed_batch(input int b, input int n);
        for (int i = 0; i < n; i++) begin
            cm_in    = vec[b][i].cm;
            salt_in  = vec[b][i].salt;
            cm_valid = 1'b1;
            check("cm_ready_fill", HW'(cm_ready), HW'(1));
            step();
        end
        cm_valid = 1'b0;
        salt_in  = '0;
    endtask

    task automatic check_slices(input int b);
        for (int i = 0; i < NL; i++) begin
            check("leaf_slice", HW'(ch[(NL - i) * HW - 1 -: 8]), HW'(vec[b][i].tag));
        end
        check("salt_latched", salt, batch_salt[b]);
    endtask

    initial begin
        batch_salt[0] = 256'hA5;
        batch_salt[1] = 256'h5A;
        batch_salt[2] = 256'h3C;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < NL; i++) begin
                vec[b][i].tag  = 8'(b * 16 + i);
                vec[b][i].cm   = {vec[b][i].tag, 248'h0};
                vec[b][i].salt = (i == 0) ? batch_salt[b] : {HW{1'b1}};
            end
        end

        reset        = 1'b0;
        cm_in        = '0;
        cm_valid     = 1'b0;
        salt_in      = '0;
        tree_set_end = 1'b0;
        chroot       = '0;
        root_ready   = 1'b0;

        // Reset and idle state
        repeat (3) step();
        reset = 1'b1;
        check("rst_cm_ready", HW'(cm_ready), HW'(1));
        check("rst_tree_start", HW'(tree_start), HW'(0));
        check("rst_root_valid", HW'(root_valid), HW'(0));
        check("rst_root_out", root_out, HW'(0));
        check("rst_salt", salt, HW'(0));
        check("rst_ch", HW'(|ch), HW'(0));
`ifdef MERKLE_COLLECTOR_PERF_EN
        check("rst_tree_cycles", HW'(tree_cycles), HW'(0));
`endif

        // First batch, launch timing
        feed_batch(0, NL);
        check("launch_no_start", HW'(tree_start), HW'(0));
        check("launch_cm_ready", HW'(cm_ready), HW'(0));
        step();
        check("start_rise", HW'(tree_start), HW'(1));
        check_slices(0);

        // Tree completes after 40 cycles
        repeat (40) step();
        check("busy_start_held", HW'(tree_start), HW'(1));
        tree_set_end = 1'b1;
        chroot       = 256'hDEAD;
        step();
        tree_set_end = 1'b0;
        chroot       = '0;
        check("root_out", root_out, 256'hDEAD);
        check("root_valid", HW'(root_valid), HW'(1));
        check("root_start_low", HW'(tree_start), HW'(0));
`ifdef MERKLE_COLLECTOR_PERF_EN
        check("tree_cycles", HW'(tree_cycles), HW'(40));
`endif

        // Consumer stall while the source keeps offering data
        cm_valid = 1'b1;
        cm_in    = {8'hEE, 248'h0};
        for (int c = 0; c < 10; c++) begin
            step();
            check("stall_cm_ready", HW'(cm_ready), HW'(0));
            check("stall_root_out", root_out, 256'hDEAD);
            check("stall_root_valid", HW'(root_valid), HW'(1));
        end
        root_ready = 1'b1;
        step();
        cm_valid   = 1'b0;
        root_ready = 1'b0;
        check("xfer_root_valid", HW'(root_valid), HW'(0));
        check("xfer_cm_ready", HW'(cm_ready), HW'(1));
        check("xfer_ch_cleared", HW'(|ch), HW'(0));

        // Stale done flag held through the second batch
        tree_set_end = 1'b1;
        feed_batch(1, NL);
        for (int c = 0; c < 3; c++) begin
            check("stale_no_start", HW'(tree_start), HW'(0));
            step();
        end
        check("stale_still_waiting", HW'(tree_start), HW'(0));
        tree_set_end = 1'b0;
        step();
        check("stale_start_rise", HW'(tree_start), HW'(1));
        check_slices(1);

        // Reset in BUSY, then a partial batch discarded by another reset
        repeat (2) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("busy_rst_cm_ready", HW'(cm_ready), HW'(1));
        check("busy_rst_start", HW'(tree_start), HW'(0));
        check("busy_rst_ch", HW'(|ch), HW'(0));
        check("busy_rst_salt", salt, HW'(0));
        feed_batch(2, 4);
        check("partial_leaf3", HW'(ch[(NL - 3) * HW - 1 -: 8]), HW'(vec[2][3].tag));
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("partial_rst_ch", HW'(|ch), HW'(0));

        // Clean batch with root_ready held high
        feed_batch(2, NL);
        check("clean_launch", HW'(tree_start), HW'(0));
        step();
        check("clean_start", HW'(tree_start), HW'(1));
        check_slices(2);
        root_ready = 1'b1;
        repeat (40) step();
        tree_set_end = 1'b1;
        chroot       = 256'hBEEF;
        step();
        tree_set_end = 1'b0;
        check("pulse_root_valid", HW'(root_valid), HW'(1));
        check("pulse_root_out", root_out, 256'hBEEF);
`ifdef MERKLE_COLLECTOR_PERF_EN
        check("clean_tree_cycles", HW'(tree_cycles), HW'(40));
`endif
        step();
        check("pulse_valid_drop", HW'(root_valid), HW'(0));
        check("pulse_cm_ready", HW'(cm_ready), HW'(1));
        check("pulse_root_held", root_out, 256'hBEEF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
